// File: rtl/kws_result_argmax.sv
// Captures one frame of signed class scores from the CNN accelerator, tracks the
// running argmax, and holds the frame for readback until software re-arms it.
module kws_result_argmax #(
   parameter int NUM_CLASSES = 12,
   parameter int DATA_W      = 8,
   parameter int IDX_W       = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_valid,
   input  logic              accel_done,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [IDX_W-1:0]  class_idx,
   output logic [DATA_W-1:0] class_score,
   output logic [IDX_W:0]    count,
   output logic              result_ready,
   output logic              irq,
   output logic              short_frame,
   output logic              overflow
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam int             DEPTH      = 2 ** IDX_W;
   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(NUM_CLASSES);

   logic [1:0]        state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] best;
   logic [IDX_W-1:0]  best_idx;
   logic [IDX_W:0]    count_inc;
   logic [IDX_W-1:0]  wr_idx;

   assign count_inc = count + 1'b1;
   assign wr_idx    = count[IDX_W-1:0];

   // NOTE: all state below is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         count       <= '0;
         best        <= '0;
         best_idx    <= '0;
         irq         <= 1'b0;
         short_frame <= 1'b0;
         overflow    <= 1'b0;
         // NOTE: the score buffer is deliberately reset, so readback after reset
         // is defined; this costs a reset net on every storage flop.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         irq <= 1'b0;
         if (clear) begin
            state       <= ST_IDLE;
            count       <= '0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (res_valid) begin
                     mem[0]   <= res_data;
                     best     <= res_data;
                     best_idx <= '0;
                     count    <= (IDX_W + 1)'(1);
                     state    <= ST_COLLECT;
                  end
               end
               ST_COLLECT: begin
                  if (res_valid) begin
                     mem[wr_idx] <= res_data;
                     // Strict greater-than so ties keep the lower index.
                     if ($signed(res_data) > $signed(best)) begin
                        best     <= res_data;
                        best_idx <= wr_idx;
                     end
                     count <= count_inc;
                     if (count_inc == FULL_COUNT) begin
                        state <= ST_DONE;
                        irq   <= 1'b1;
                     end else if (accel_done) begin
                        state       <= ST_DONE;
                        irq         <= 1'b1;
                        short_frame <= 1'b1;
                     end
                  end else if (accel_done) begin
                     state       <= ST_DONE;
                     irq         <= 1'b1;
                     short_frame <= 1'b1;
                  end
               end
               ST_DONE: begin
                  if (res_valid) overflow <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if ({1'b0, rd_addr} < FULL_COUNT) begin
         rd_data <= mem[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

   assign result_ready = (state == ST_DONE);
   assign class_idx    = result_ready ? best_idx : '0;
   assign class_score  = result_ready ? best : '0;

endmodule

// File: tb/tb_kws_result_argmax.sv
// Directed bench for kws_result_argmax: full, tied, short, overflow/clear,
// readback and asynchronous-reset frames with hand-computed expectations.
module tb_kws_result_argmax;

   logic       clk;
   logic       reset_n;
   logic       clear;
   logic [7:0] res_data;
   logic       res_valid;
   logic       accel_done;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [3:0] class_idx;
   logic [7:0] class_score;
   logic [4:0] count;
   logic       result_ready;
   logic       irq;
   logic       short_frame;
   logic       overflow;

   int vectors;
   int miscompares;

   kws_result_argmax #(.NUM_CLASSES(12), .DATA_W(8), .IDX_W(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear),
      .res_data     (res_data),
      .res_valid    (res_valid),
      .accel_done   (accel_done),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .class_idx    (class_idx),
      .class_score  (class_score),
      .count        (count),
      .result_ready (result_ready),
      .irq          (irq),
      .short_frame  (short_frame),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; presents one byte for the next rising edge.
   task automatic push(input logic [7:0] b, input logic done);
      res_data   = b;
      res_valid  = 1'b1;
      accel_done = done;
      @(negedge clk);
      res_valid  = 1'b0;
      accel_done = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      @(negedge clk);
      check(tag, rd_data, exp);
   endtask

   logic [7:0] frame1 [12];

   initial begin
      vectors     = 0;
      miscompares = 0;
      frame1 = '{8'd0, 8'd5, 8'hFD, 8'd7, 8'd2, 8'd7, 8'd1, 8'd0, 8'h80, 8'h7F, 8'd4, 8'd3};
      reset_n = 1'b0; clear = 1'b0; res_data = '0; res_valid = 1'b0;
      accel_done = 1'b0; rd_addr = '0;
      #12;
      check("rst_ready", result_ready, 0);
      check("rst_irq", irq, 0);
      check("rst_count", count, 0);
      check("rst_idx", class_idx, 0);
      check("rst_score", class_score, 0);
      check("rst_flags", {short_frame, overflow}, 0);
      check("rst_rd", rd_data, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // accel_done in IDLE must not start or finish anything
      accel_done = 1'b1;
      @(negedge clk);
      accel_done = 1'b0;
      check("idle_done_ign", {result_ready, short_frame}, 0);

      // Full frame
      for (int i = 0; i < 11; i++) push(frame1[i], 1'b0);
      check("f1_pre_ready", result_ready, 0);
      check("f1_pre_count", count, 11);
      push(frame1[11], 1'b0);
      check("f1_ready", result_ready, 1);
      check("f1_irq", irq, 1);
      check("f1_idx", class_idx, 9);
      check("f1_score", class_score, 8'h7F);
      check("f1_count", count, 12);
      check("f1_short", short_frame, 0);
      @(negedge clk);
      check("f1_irq_pulse", irq, 0);
      check("f1_ready_hold", result_ready, 1);

      // Readback of the whole frame plus out-of-range addresses
      for (int i = 0; i < 12; i++) read_check($sformatf("rd%0d", i), 4'(i), frame1[i]);
      read_check("rd12", 4'd12, 8'h00);
      read_check("rd13", 4'd13, 8'h00);

      // Overflow in DONE leaves results and buffer untouched
      push(8'h7E, 1'b0);
      push(8'h55, 1'b0);
      check("ovf_flag", overflow, 1);
      check("ovf_idx", class_idx, 9);
      check("ovf_count", count, 12);
      check("ovf_irq", irq, 0);
      read_check("ovf_rd1", 4'd1, 8'd5);

      // clear with same-cycle res_valid: byte discarded
      clear = 1'b1; res_valid = 1'b1; res_data = 8'h11;
      @(negedge clk);
      clear = 1'b0; res_valid = 1'b0;
      check("clr_ready", result_ready, 0);
      check("clr_count", count, 0);
      check("clr_ovf", overflow, 0);
      check("clr_idx", class_idx, 0);
      read_check("clr_keep3", 4'd3, 8'd7);
      read_check("clr_keep0", 4'd0, 8'd0);

      // All-equal negative frame: tie keeps index 0
      for (int i = 0; i < 12; i++) push(8'hF0, 1'b0);
      check("tie_idx", class_idx, 0);
      check("tie_score", class_score, 8'hF0);
      do_clear();

      // All minimum except the last
      for (int i = 0; i < 11; i++) push(8'h80, 1'b0);
      push(8'h81, 1'b0);
      check("min_idx", class_idx, 11);
      check("min_score", class_score, 8'h81);
      do_clear();

      // Short frame ended by accel_done
      push(8'd1, 1'b0); push(8'd9, 1'b0); push(8'd3, 1'b0);
      push(8'd9, 1'b0); push(8'd2, 1'b0);
      accel_done = 1'b1;
      @(negedge clk);
      accel_done = 1'b0;
      check("sh_ready", result_ready, 1);
      check("sh_irq", irq, 1);
      check("sh_flag", short_frame, 1);
      check("sh_count", count, 5);
      check("sh_idx", class_idx, 1);
      check("sh_score", class_score, 8'd9);
      read_check("sh_keep5", 4'd5, 8'h80);
      read_check("sh_rd4", 4'd4, 8'd2);
      do_clear();
      check("sh_clr_flag", short_frame, 0);

      // accel_done together with the 12th byte: full frame, byte counted
      for (int i = 0; i < 11; i++) push(8'(i + 1), 1'b0);
      push(8'h40, 1'b1);
      check("sc_ready", result_ready, 1);
      check("sc_short", short_frame, 0);
      check("sc_count", count, 12);
      check("sc_idx", class_idx, 11);
      check("sc_score", class_score, 8'h40);
      do_clear();

      // Asynchronous reset mid-frame
      for (int i = 0; i < 6; i++) push(8'(8'h20 + i), 1'b0);
      check("ar_pre_count", count, 6);
      #2 reset_n = 1'b0;
      #1;
      check("ar_count", count, 0);
      check("ar_ready", {result_ready, irq, short_frame, overflow}, 0);
      check("ar_idx", {class_idx, class_score}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      read_check("ar_buf3", 4'd3, 8'h00);
      check("ar_idle", result_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/kws_result_argmax.md
Name: kws_result_argmax

Overview:
Sits directly downstream of the CNN accelerator's serial result port. Captures one frame of NUM_CLASSES signed 8-bit class scores into a local buffer. Tracks the running argmax as the scores arrive. On frame completion it presents the winning keyword index and score, raises a one-cycle interrupt pulse, and holds the frame for software readback via the logic-analyzer or wishbone side.

Parameters:
NUM_CLASSES, 12, number of class scores per frame (2..16)
DATA_W, 8, score width in bits; scores are two's-complement signed
IDX_W, 4, width of class index and buffer address; must satisfy 2^IDX_W >= NUM_CLASSES

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous re-arm; returns block to IDLE
res_data  in  DATA_W  score byte from accelerator serial_result
res_valid  in  1  res_data valid this cycle; no backpressure
accel_done  in  1  accelerator done, single-cycle or level
rd_addr  in  IDX_W  buffer read address
rd_data  out  DATA_W  buffer word at rd_addr, registered
class_idx  out  IDX_W  argmax index
class_score  out  DATA_W  score at class_idx
count  out  IDX_W+1  scores captured in current frame
result_ready  out  1  level; frame complete, outputs stable
irq  out  1  one-cycle pulse on entry to DONE
short_frame  out  1  sticky; frame ended by accel_done with count < NUM_CLASSES
overflow  out  1  sticky; res_valid received while in DONE

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE.
  - All outputs are 0.
  - Buffer entries are 0.
  - Best score register is 0 and best index register is 0.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - res_valid: store res_data at buffer[0], best = res_data, best_idx = 0, count = 1, go to COLLECT.
  - If NUM_CLASSES were 1 this would go straight to DONE; the parameter range excludes it.
  - accel_done in IDLE is ignored.
- COLLECT, on each res_valid:
  - Write buffer[count].
  - If signed(res_data) > signed(best): update best and best_idx.
  - Ties keep the lower index (strict greater-than).
  - count increments.
  - When the accepted byte makes count == NUM_CLASSES, go to DONE on the same edge.
- COLLECT, early end: accel_done with count < NUM_CLASSES goes to DONE and sets short_frame.
  - Argmax covers the received bytes only.
  - Unwritten buffer entries keep their previous contents.
- Same cycle res_valid and accel_done in COLLECT: the byte is accepted first.
  - short_frame is set only if count after the accept is still < NUM_CLASSES.
- DONE:
  - result_ready = 1.
  - class_idx and class_score show best_idx and best.
  - irq is high exactly the first cycle result_ready is high.
  - res_valid is dropped and sets overflow; buffer and argmax are unchanged.
  - accel_done is ignored.
  - Stays in DONE until clear.
- clear (any state): next edge state = IDLE, and count, result_ready, class_idx, class_score, short_frame, overflow and irq are zeroed.
  - Buffer contents are retained.
  - clear has priority over a same-cycle res_valid; that byte is discarded.
- Latency:
  - class_idx and class_score are valid in the cycle result_ready first rises, which is one edge after the last accepted byte.
  - rd_data = buffer[rd_addr] one cycle after rd_addr is presented.
  - rd_addr >= NUM_CLASSES returns 0.
- Comparisons are signed over DATA_W bits; 8'h80 (-128) is the minimum value.
- count saturates at NUM_CLASSES.
- Reset asserted mid-frame aborts immediately; no partial result is flagged.

Test Plan:
- Full frame, NUM_CLASSES = 12: scores 0,5,-3,7,2,7,1,0,-128,127,4,3, one byte per cycle -> class_idx=9, class_score=127, count=12, result_ready one edge after the 12th byte, irq high exactly 1 cycle, short_frame=0.
- Ties and all-negative: twelve bytes of 8'hF0 -> class_idx=0, class_score=8'hF0; a second frame of all 8'h80 except index 11 = 8'h81 -> class_idx=11.
- Short frame: 5 bytes (1,9,3,9,2) then accel_done -> DONE, short_frame=1, count=5, class_idx=1, class_score=9.
- Same cycle on byte 12: accel_done with the 12th byte -> short_frame=0, count=12; the byte is included in the argmax.
- Overflow and clear: 2 extra res_valid in DONE -> overflow=1, outputs unchanged; then clear asserted together with res_valid -> IDLE, byte discarded, count=0, overflow=0; the next frame captures normally.
- Readback and async reset: after a full frame, rd_addr 0..11 returns the stored bytes 1 cycle later, and rd_addr=13 returns 0. Then reset_n pulsed low mid-frame (after 6 bytes) -> all outputs 0 immediately, without waiting for a clock edge.
